// File: rtl/piso_load_shifter.sv
// Parallel-in/serial-out loader: takes a word over valid/ready and shifts it out LSB-first,
// one bit per SP-enabled cycle. Define PISO_PARITY_EN to append an even-parity bit per frame.
module piso_load_shifter #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             SP,
  input  logic [WIDTH-1:0] LD_DATA,
  input  logic             LD_VALID,
  output logic             LD_READY,
  output logic             SO,
  output logic             SO_VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last_pos;
  logic             load;
  logic             end_word;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;

  assign last_pos = (state_q == S_PAR);
`else
  assign last_pos = (state_q == S_SHIFT) && (cnt_q == LAST);
`endif

  // The only input-to-output path: lets a new word land on the edge that retires the old one.
  assign LD_READY = (state_q == S_IDLE) | (SP & last_pos);
  assign load     = LD_VALID & LD_READY;
  assign end_word = SP & last_pos;

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise an unassigned path infers a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (end_word) begin
      done_d  = 1'b1;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if ((state_q == S_SHIFT) && SP) begin
`ifdef PISO_PARITY_EN
      if (cnt_q == LAST) begin
        state_d = S_PAR;
        cnt_d   = '0;
      end else begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CW'(1);
      end
`else
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + CW'(1);
`endif
    end
    // A load overrides the end-of-word return to IDLE, giving back-to-back frames with no gap.
    if (load) begin
      shreg_d = LD_DATA;
      cnt_d   = '0;
      state_d = S_SHIFT;
`ifdef PISO_PARITY_EN
      par_d   = ^LD_DATA;
`endif
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    SO = IDLE_LEVEL;
    case (state_q)
      S_SHIFT: SO = shreg_q[0];
`ifdef PISO_PARITY_EN
      S_PAR:   SO = par_q;
`endif
      default: SO = IDLE_LEVEL;
    endcase
  end

  assign SO_VALID = (state_q != S_IDLE);
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = done_q;

endmodule

// File: tb/tb_piso_load_shifter.sv
// Directed bench for piso_load_shifter: an 8-bit instance for the main scenarios and a
// 2-bit instance for the counter boundary. Follows PISO_PARITY_EN if defined.
module tb_piso_load_shifter;

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME  = PAR_EN ? 9 : 8;
  localparam int FRAME2 = PAR_EN ? 3 : 2;

  typedef struct {
    logic       sp;
    logic       ldv;
    logic [7:0] d;
    logic       so;
    logic       vld;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;

  logic       CK = 1'b0;
  logic       RSTN;
  logic       SP, LD_VALID;
  logic [7:0] LD_DATA;
  logic       LD_READY, SO, SO_VALID, BUSY, DONE;

  logic       sp2, ldv2;
  logic [1:0] d2;
  logic       rdy2, so2, vld2, busy2, done2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CK = ~CK;

  piso_load_shifter #(.WIDTH(8), .IDLE_LEVEL(1'b1)) u_dut (
    .CK(CK), .RSTN(RSTN), .SP(SP), .LD_DATA(LD_DATA), .LD_VALID(LD_VALID),
    .LD_READY(LD_READY), .SO(SO), .SO_VALID(SO_VALID), .BUSY(BUSY), .DONE(DONE)
  );

  piso_load_shifter #(.WIDTH(2), .IDLE_LEVEL(1'b1)) u_dut2 (
    .CK(CK), .RSTN(RSTN), .SP(sp2), .LD_DATA(d2), .LD_VALID(ldv2),
    .LD_READY(rdy2), .SO(so2), .SO_VALID(vld2), .BUSY(busy2), .DONE(done2)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Expected frame bit i of word w: data LSB-first, then even parity when enabled.
  function automatic logic fbit(input logic [7:0] w, input int i);
    logic [7:0] t;
    t = w;
    return (i < 8) ? t[i] : ^t;
  endfunction

  function automatic vec_t mk(input logic sp, input logic ldv, input logic [7:0] d,
                              input logic so, input logic vld, input logic busy,
                              input logic done, input logic rdy);
    vec_t v;
    v.sp = sp; v.ldv = ldv; v.d = d;
    v.so = so; v.vld = vld; v.busy = busy; v.done = done; v.rdy = rdy;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, then check the outputs of that cycle.
  task automatic step(input string tag, input vec_t v);
    @(negedge CK);
    SP = v.sp; LD_VALID = v.ldv; LD_DATA = v.d;
    #1;
    check({tag, " SO"},       SO,       v.so);
    check({tag, " SO_VALID"}, SO_VALID, v.vld);
    check({tag, " BUSY"},     BUSY,     v.busy);
    check({tag, " DONE"},     DONE,     v.done);
    check({tag, " LD_READY"}, LD_READY, v.rdy);
  endtask

  task automatic step2(input string tag, input logic sp, input logic ldv, input logic [1:0] d,
                       input logic so, input logic vld, input logic done, input logic rdy);
    @(negedge CK);
    sp2 = sp; ldv2 = ldv; d2 = d;
    #1;
    check({tag, " SO"},       so2,   so);
    check({tag, " SO_VALID"}, vld2,  vld);
    check({tag, " BUSY"},     busy2, vld);
    check({tag, " DONE"},     done2, done);
    check({tag, " LD_READY"}, rdy2,  rdy);
  endtask

  vec_t tbl[$];

  initial begin
    logic [1:0] exp2 [3];
    RSTN = 1'b0; SP = 1'b0; LD_VALID = 1'b0; LD_DATA = '0;
    sp2 = 1'b0; ldv2 = 1'b0; d2 = '0;

    // Reset state, before any clock edge.
    #1;
    check("rst SO", SO, 1'b1);
    check("rst SO_VALID", SO_VALID, 1'b0);
    check("rst BUSY", BUSY, 1'b0);
    check("rst DONE", DONE, 1'b0);
    @(negedge CK);
    RSTN = 1'b1;
    step("idle", mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

    // 8'hA5 with SP held high: 1,0,1,0,0,1,0,1 then DONE once.
    step("a5 load", mk(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < FRAME; i++)
      step($sformatf("a5 bit%0d", i),
           mk(1'b1, 1'b0, 8'h00, fbit(8'hA5, i), 1'b1, 1'b1, 1'b0, i == FRAME - 1));
    step("a5 done", mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    step("a5 idle", mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

    // 8'h01 with SP alternating 0,1: each bit held through its stall cycle.
    tbl.push_back(mk(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, !PAR_EN));
    if (PAR_EN) begin
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    end
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    foreach (tbl[i]) step($sformatf("stall c%0d", i), tbl[i]);

    // Back-to-back 8'hFF then 8'h00 with LD_VALID held: SO_VALID never drops.
    step("b2b load", mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < FRAME; i++)
      step($sformatf("b2b ff%0d", i),
           mk(1'b1, 1'b1, 8'h00, fbit(8'hFF, i), 1'b1, 1'b1, 1'b0, i == FRAME - 1));
    for (int i = 0; i < FRAME; i++)
      step($sformatf("b2b 00_%0d", i),
           mk(1'b1, 1'b0, 8'h00, fbit(8'h00, i), 1'b1, 1'b1, i == 0, i == FRAME - 1));
    step("b2b done", mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));

    // 8'h3C offered mid-word of 8'h81: refused until the last position.
    step("mid load", mk(1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < FRAME; i++)
      step($sformatf("mid 81_%0d", i),
           mk(1'b1, i >= 3, (i >= 3) ? 8'h3C : 8'h00, fbit(8'h81, i), 1'b1, 1'b1, 1'b0,
              i == FRAME - 1));
    for (int i = 0; i < FRAME; i++)
      step($sformatf("mid 3c_%0d", i),
           mk(1'b1, 1'b0, 8'h00, fbit(8'h3C, i), 1'b1, 1'b1, i == 0, i == FRAME - 1));
    step("mid done", mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));

    // Reset mid-word: outputs return to idle without a clock, and no DONE follows.
    step("rst load", mk(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++)
      step($sformatf("rst 5a_%0d", i),
           mk(1'b1, 1'b0, 8'h00, fbit(8'h5A, i), 1'b1, 1'b1, 1'b0, 1'b0));
    RSTN = 1'b0;
    #1;
    check("midrst SO", SO, 1'b1);
    check("midrst SO_VALID", SO_VALID, 1'b0);
    check("midrst BUSY", BUSY, 1'b0);
    check("midrst DONE", DONE, 1'b0);
    @(negedge CK);
    RSTN = 1'b1;
    step("post rst", mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    step("post rst2", mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

    // Reset on the DONE cycle clears the pulse immediately.
    step("drst load", mk(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < FRAME; i++)
      step($sformatf("drst bit%0d", i),
           mk(1'b1, 1'b0, 8'h00, fbit(8'h01, i), 1'b1, 1'b1, 1'b0, i == FRAME - 1));
    step("drst done", mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    RSTN = 1'b0;
    #1;
    check("drst DONE cleared", DONE, 1'b0);
    @(negedge CK);
    RSTN = 1'b1;

    // WIDTH=2 instance: 2'b10 goes out as 0,1 (then parity 1 when enabled).
    exp2[0] = 2'b00; exp2[1] = 2'b01; exp2[2] = 2'b01;
    step2("w2 load", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < FRAME2; i++)
      step2($sformatf("w2 bit%0d", i), 1'b1, 1'b0, 2'b00, exp2[i][0], 1'b1, 1'b0,
            i == FRAME2 - 1);
    step2("w2 done", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    step2("w2 idle", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
